// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate truth-table checker: gate selectors, FSM states and the settle-counter width.
// Pure declarations: no latency and no flow control apply here.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int SETTLE_W = 8;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden value of the selected gate for one stimulus vector.
// Zero latency with no flow control; BUF/NOT look at vec[0], and all other gates reduce across every bit.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] vec,
    output logic            exp_y
);

    always_comb begin
        exp_y = 1'b0;
        case (op_e'(op))
            OP_BUF:  exp_y = vec[0];
            OP_NOT:  exp_y = ~vec[0];
            OP_AND:  exp_y = &vec;
            OP_OR:   exp_y = |vec;
            OP_NAND: exp_y = ~&vec;
            OP_NOR:  exp_y = ~|vec;
            OP_XOR:  exp_y = ^vec;
            OP_XNOR: exp_y = ~^vec;
            default: exp_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps every stimulus vector through a gate under test and compares each response with the reference model.
// A sweep takes 2^N_IN*(SETTLE_CYCLES+1) cycles; start is ignored while busy, and a start seen in DONE chains a new sweep.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail
);

    localparam logic [N_IN-1:0]     STIM_ONE    = N_IN'(1);
    localparam logic [N_IN:0]       ERR_ONE     = (N_IN+1)'(1);
    localparam logic [SETTLE_W-1:0] CNT_ONE     = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_e              state;
    state_e              state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [2:0]          op_lat;
    logic                exp_y;
    logic                mismatch;
    logic                stim_last;
    logic                accept;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .op    (op_lat),
        .vec   (stim),
        .exp_y (exp_y)
    );

    assign mismatch  = (resp != exp_y);
    assign stim_last = &stim;
    // DONE accepts start as well, so a held start gives back-to-back sweeps with no idle gap.
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt <= CNT_ONE) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = stim_last ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = start ? S_SETTLE : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim       <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            settle_cnt <= '0;
            op_lat     <= '0;
        end else if (accept) begin
            op_lat     <= op;
            stim       <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == S_SETTLE) begin
            if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_ONE;
        end else if (state == S_SAMPLE) begin
            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + ERR_ONE;
                if (err_count == '0) first_fail <= stim;
            end
            // pass must include the verdict on this final vector, not just the count so far.
            if (stim_last) begin
                busy <= 1'b0;
                pass <= (err_count == '0) && !mismatch;
            end else begin
                stim       <= stim + STIM_ONE;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: one checker with SETTLE_CYCLES=4 driven by a selectable fake gate, one with SETTLE_CYCLES=1 under a held start.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_gate_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [2:0] op_a, op_b;
    logic [1:0] stim_a, stim_b;
    logic       resp_a, resp_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [2:0] err_a, err_b;
    logic [1:0] ff_a, ff_b;
    int         mode_a;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .op(op_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
    );

    gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .op(op_b), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
    );

    // Fake gates: 0 NOR-built inverter, 1 stuck-at-0, 2 stuck-at-1, otherwise a correct 2-input AND.
    always_comb begin
        case (mode_a)
            0:       resp_a = ~(stim_a[0] | stim_a[0]);
            1:       resp_a = 1'b0;
            2:       resp_a = 1'b1;
            default: resp_a = stim_a[0] & stim_a[1];
        endcase
    end
    assign resp_b = stim_b[0] ^ stim_b[1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic sweep_a(input string name, input logic [2:0] op_v, input int md, input bit disturb,
                           input int exp_err, input int exp_ff, input bit exp_pass);
        int   done_at, n_done, stim_bad;
        logic busy0, busy_done, pass_done;
        done_at = -1; n_done = 0; stim_bad = 0;
        busy0 = 1'b0; busy_done = 1'b1; pass_done = 1'b0;
        @(negedge clk);
        op_a = op_v; mode_a = md; start_a = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_a = 1'b0;
                busy0   = busy_a;
            end
            if (disturb && k == 8) begin
                start_a = 1'b1;
                op_a    = 3'd3;
            end
            if (disturb && k == 9) start_a = 1'b0;
            if (k < 20 && stim_a != 2'(k / 5)) stim_bad++;
            if (done_a) begin
                n_done++;
                if (done_at < 0) begin
                    done_at   = k;
                    busy_done = busy_a;
                    pass_done = pass_a;
                end
            end
        end
        chk({name, "/busy_start"},  32'(busy0), 1);
        chk({name, "/stim_seq"},    stim_bad, 0);
        chk({name, "/done_cycle"},  done_at, 20);
        chk({name, "/done_count"},  n_done, 1);
        chk({name, "/busy_done"},   32'(busy_done), 0);
        chk({name, "/pass_done"},   32'(pass_done), 32'(exp_pass));
        chk({name, "/pass_hold"},   32'(pass_a), 32'(exp_pass));
        chk({name, "/err_count"},   32'(err_a), exp_err);
        chk({name, "/first_fail"},  32'(ff_a), exp_ff);
        chk({name, "/stim_nowrap"}, 32'(stim_a), 3);
    endtask

    initial begin
        int n_done, first, t_last, gap_bad, pass_bad;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        op_a = 3'd0; op_b = 3'd6; mode_a = 0;
        #1;
        chk("rst/stim",  32'(stim_a), 0);
        chk("rst/busy",  32'(busy_a), 0);
        chk("rst/done",  32'(done_a), 0);
        chk("rst/pass",  32'(pass_a), 0);
        chk("rst/err",   32'(err_a), 0);
        chk("rst/ff",    32'(ff_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        sweep_a("t1_not",     3'd1, 0, 1'b0, 0, 0, 1'b1);
        sweep_a("t2_and_sa0", 3'd2, 1, 1'b0, 1, 3, 1'b0);
        sweep_a("t3_nor_sa1", 3'd5, 2, 1'b0, 3, 1, 1'b0);
        sweep_a("t4_disturb", 3'd2, 3, 1'b1, 0, 0, 1'b1);

        // Abort a NOR stuck-at-1 sweep after its first mismatch has been recorded.
        @(negedge clk);
        op_a = 3'd5; mode_a = 2; start_a = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) start_a = 1'b0;
        end
        chk("t5/stim_pre", 32'(stim_a), 2);
        chk("t5/err_pre",  32'(err_a), 1);
        chk("t5/busy_pre", 32'(busy_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5/stim_rst", 32'(stim_a), 0);
        chk("t5/busy_rst", 32'(busy_a), 0);
        chk("t5/err_rst",  32'(err_a), 0);
        chk("t5/ff_rst",   32'(ff_a), 0);
        chk("t5/done_rst", 32'(done_a), 0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (done_a) n_done++;
        end
        chk("t5/no_done", n_done, 0);
        sweep_a("t5_after", 3'd5, 2, 1'b0, 3, 1, 1'b0);

        // Held start on the short-settle instance: DONE chains straight into the next sweep.
        @(negedge clk);
        start_b = 1'b1;
        n_done = 0; first = -1; t_last = -1; gap_bad = 0; pass_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_b) begin
                if (first < 0) first = k;
                else if (k - t_last != 9) gap_bad++;
                t_last = k;
                n_done++;
                if (pass_b !== 1'b1 || busy_b !== 1'b0) pass_bad++;
            end
        end
        start_b = 1'b0;
        chk("t6/first_done", first, 8);
        chk("t6/done_count", n_done, 4);
        chk("t6/gap",        gap_bad, 0);
        chk("t6/pass",       pass_bad, 0);
        chk("t6/err",        32'(err_b), 0);
        chk("t6/ff",         32'(ff_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
